// File: rtl/gpu_fb_pkg.sv
// Shared framebuffer geometry, controller state encoding and pixel address mapping
// for the 320x200 monochrome framebuffer.
package gpu_fb_pkg;

    localparam int unsigned FB_W     = 320;
    localparam int unsigned FB_H     = 200;
    localparam int unsigned BPL      = 40;
    localparam int unsigned AW       = 13;
    localparam int unsigned FB_BYTES = 8000;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StCapture,
        StWriteback,
        StDone
    } fb_state_e;

    // y*40 built from shifts; exact for every in-range pixel (max 7999)
    function automatic logic [AW-1:0] pix_byte_addr(input logic [8:0] x, input logic [7:0] y);
        logic [AW-1:0] yw;
        yw = AW'(y);
        return (yw << 5) + (yw << 3) + AW'(x[8:3]);
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational pixel (x,y) to framebuffer byte address, bit index and range flag.
// Bit 0 of each byte is the leftmost of its eight pixels.
module fb_addr_calc
    import gpu_fb_pkg::*;
(
    input  logic [8:0]    x,
    input  logic [7:0]    y,
    output logic [AW-1:0] byte_addr,
    output logic [2:0]    bit_idx,
    output logic          in_range
);

    assign byte_addr = pix_byte_addr(x, y);
    assign bit_idx   = x[2:0];
    assign in_range  = (x < 9'(FB_W)) && (y < 8'(FB_H));

endmodule

// File: rtl/fb_pixel_port.sv
// Single-pixel read / read-modify-write port onto a byte-wide synchronous framebuffer RAM,
// sharing the RAM port with the scanout byte fetcher.
module fb_pixel_port
    import gpu_fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [8:0]    x_b,
    input  logic [7:0]    y_b,
    input  logic          read_b,
    input  logic          write_b,
    input  logic          in_b,
    output logic          out_b,
    output logic          rdy_b,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic [7:0]    scan_data,
    output logic          scan_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    fb_state_e state_q, state_d;

    // Pending flags stay set until the op completes, so they also mean "in flight".
    logic          pix_pend_q;
    logic          pix_wr_q;
    logic [8:0]    pix_x_q;
    logic [7:0]    pix_y_q;
    logic          pix_val_q;
    logic          scan_pend_q;
    logic [AW-1:0] scan_addr_q;
    logic          op_scan_q;
    logic          last_scan_q;

    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [7:0]    mem_wdata_q;
    logic          out_b_q;
    logic [7:0]    scan_data_q;

    logic [AW-1:0] pix_addr;
    logic [2:0]    pix_bit;
    logic          pix_in_range;
    logic          pick_pix;
    logic          pix_strobe;
    logic [7:0]    wdata_merge;

    fb_addr_calc u_addr_calc (
        .x         (pix_x_q),
        .y         (pix_y_q),
        .byte_addr (pix_addr),
        .bit_idx   (pix_bit),
        .in_range  (pix_in_range)
    );

    // Scan normally wins; right after a scan access a waiting pixel op goes first.
    assign pick_pix   = pix_pend_q && (!scan_pend_q || last_scan_q);
    assign pix_strobe = (read_b || write_b) && !pix_pend_q;

    always_comb begin
        wdata_merge          = mem_rdata;
        wdata_merge[pix_bit] = pix_val_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pick_pix) begin
                    state_d = pix_in_range ? StIssue : StDone;
                end else if (scan_pend_q) begin
                    state_d = StIssue;
                end
            end
            StIssue:     state_d = StCapture;
            StCapture: begin
                if (op_scan_q) begin
                    state_d = StIdle;
                end else if (pix_wr_q) begin
                    state_d = StWriteback;
                end else begin
                    state_d = StDone;
                end
            end
            StWriteback: state_d = StDone;
            StDone:      state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_pend_q  <= 1'b0;
            pix_wr_q    <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_val_q   <= 1'b0;
            scan_pend_q <= 1'b0;
            scan_addr_q <= '0;
            op_scan_q   <= 1'b0;
            last_scan_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            out_b_q     <= 1'b0;
            scan_data_q <= '0;
        end else begin
            if (state_q == StDone) begin
                pix_pend_q <= 1'b0;
            end else if (pix_strobe) begin
                pix_pend_q <= 1'b1;
                pix_wr_q   <= write_b;
                pix_x_q    <= x_b;
                pix_y_q    <= y_b;
                pix_val_q  <= in_b;
            end

            if (state_q == StCapture && op_scan_q) begin
                scan_pend_q <= 1'b0;
            end else if (scan_req && !scan_pend_q) begin
                scan_pend_q <= 1'b1;
                scan_addr_q <= scan_addr;
            end

            if (state_q == StIdle) begin
                if (pick_pix) begin
                    op_scan_q   <= 1'b0;
                    last_scan_q <= 1'b0;
                    if (pix_in_range) begin
                        mem_addr_q <= pix_addr;
                    end else if (!pix_wr_q) begin
                        out_b_q <= 1'b0;
                    end
                end else if (scan_pend_q) begin
                    op_scan_q  <= 1'b1;
                    mem_addr_q <= scan_addr_q;
                end
            end

            if (state_q == StCapture) begin
                if (op_scan_q) begin
                    scan_data_q <= mem_rdata;
                    last_scan_q <= 1'b1;
                end else if (pix_wr_q) begin
                    mem_wdata_q <= wdata_merge;
                end else begin
                    out_b_q <= mem_rdata[pix_bit];
                end
            end

            mem_we_q <= (state_d == StWriteback);
        end
    end

    assign rdy_b      = (state_q == StDone);
    assign scan_valid = (state_q == StCapture) && op_scan_q;
    // The fetched byte is forwarded straight from the RAM in its capture cycle.
    assign scan_data  = scan_valid ? mem_rdata : scan_data_q;
    assign out_b      = out_b_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
